// File: rtl/vbsme_pkg.sv
// Shared types and defaults for the SAD motion-estimation datapath.
package vbsme_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int COORD_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/raster_counter.sv
// Row/column raster counter over a ROWS x COLS window. Column advances on
// every enable; at the last column it wraps to 0 and the row advances.
// 'last' flags the final position of the window.
module raster_counter #(
  parameter int ROWS    = 61,
  parameter int COLS    = 61,
  parameter int COORD_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               last
);

  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(ROWS - 1);
  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(COLS - 1);

  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;

  // Next position: clear wins over advance; column wraps into the next row.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (en) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/sad_min_tracker.sv
// Consumes one SAD per candidate position in raster order, tracks the
// smallest value and its (row, col), and pulses Done once the whole search
// window has been consumed. Ties keep the earlier position (strict compare).
//
//   state | meaning
//   IDLE  | waiting for Start; last result stays on the outputs
//   SCAN  | accepting SADs, updating the running minimum
//   DONE  | one-cycle Done pulse with the final result
module sad_min_tracker
  import vbsme_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROWS    = 61,
  parameter int COLS    = 61,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic               Abort,
  input  logic [DATA_W-1:0]  SadIn,
  input  logic               SadValid,
  output logic               SadReady,
  output logic [DATA_W-1:0]  MinSad,
  output logic [COORD_W-1:0] MinRow,
  output logic [COORD_W-1:0] MinCol,
  output logic               Busy,
  output logic               Done
);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  min_sad_q, min_sad_d;
  logic [COORD_W-1:0] min_row_q, min_row_d;
  logic [COORD_W-1:0] min_col_q, min_col_d;

  logic               cnt_clr;
  logic               cnt_en;
  logic               cnt_last;
  logic [COORD_W-1:0] cnt_row;
  logic [COORD_W-1:0] cnt_col;

  raster_counter #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .COORD_W (COORD_W)
  ) u_raster_counter (
    .clk   (Clk),
    .rst_n (Rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .row   (cnt_row),
    .col   (cnt_col),
    .last  (cnt_last)
  );

  // Next-state and minimum-update logic; Abort beats a same-cycle accept.
  always_comb begin
    state_d   = state_q;
    min_sad_d = min_sad_q;
    min_row_d = min_row_q;
    min_col_d = min_col_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          min_sad_d = '1;
          min_row_d = '0;
          min_col_d = '0;
          cnt_clr   = 1'b1;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else if (SadValid) begin
          cnt_en = 1'b1;
          if (SadIn < min_sad_q) begin
            min_sad_d = SadIn;
            min_row_d = cnt_row;
            min_col_d = cnt_col;
          end
          if (cnt_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      min_sad_q <= '0;
      min_row_q <= '0;
      min_col_q <= '0;
    end else begin
      state_q   <= state_d;
      min_sad_q <= min_sad_d;
      min_row_q <= min_row_d;
      min_col_q <= min_col_d;
    end
  end

  assign SadReady = (state_q == ST_SCAN);
  assign Busy     = (state_q == ST_SCAN);
  assign Done     = (state_q == ST_DONE);
  assign MinSad   = min_sad_q;
  assign MinRow   = min_row_q;
  assign MinCol   = min_col_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Testbench for sad_min_tracker in a 3x3 window: directed scenarios plus
// randomized searches against a reference model that scans the list of SADs.
module tb_sad_min_tracker;

  localparam int N = 9;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Start;
  logic        Abort;
  logic [31:0] SadIn;
  logic        SadValid;
  logic        SadReady;
  logic [31:0] MinSad;
  logic [5:0]  MinRow;
  logic [5:0]  MinCol;
  logic        Busy;
  logic        Done;

  int errors = 0;
  int checks = 0;
  logic [31:0] cur [N];

  sad_min_tracker #(
    .DATA_W (32),
    .ROWS   (3),
    .COLS   (3),
    .COORD_W(6)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Start   (Start),
    .Abort   (Abort),
    .SadIn   (SadIn),
    .SadValid(SadValid),
    .SadReady(SadReady),
    .MinSad  (MinSad),
    .MinRow  (MinRow),
    .MinCol  (MinCol),
    .Busy    (Busy),
    .Done    (Done)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Reference: first strict minimum over the first 'cnt' samples of cur.
  task automatic model(input int cnt, output logic [31:0] m, output int idx);
    m = 32'hFFFF_FFFF;
    idx = 0;
    for (int i = 0; i < cnt; i++) begin
      if (cur[i] < m) begin
        m = cur[i];
        idx = i;
      end
    end
  endtask

  task automatic run_search(input string name, input int gap_mode);
    logic [31:0] em;
    int ei;
    int gaps;
    Start = 1'b1;
    step();
    Start = 1'b0;
    checks++;
    if (!(Busy === 1'b1 && SadReady === 1'b1 && MinSad === 32'hFFFF_FFFF &&
          MinRow === 6'd0 && MinCol === 6'd0)) begin
      errors++;
      $display("FAIL %s_init: busy=%b ready=%b min=%h row=%0d col=%0d need 1 1 ffffffff 0 0",
               name, Busy, SadReady, MinSad, MinRow, MinCol);
    end
    for (int i = 0; i < N; i++) begin
      gaps = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) step();
      SadValid = 1'b1;
      SadIn = cur[i];
      step();
      SadValid = 1'b0;
      SadIn = $urandom;
      if (i < N - 1) begin
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b1) begin
          errors++;
          $display("FAIL %s_midscan%0d: done=%b busy=%b need 0 1", name, i, Done, Busy);
        end
      end
    end
    model(N, em, ei);
    checks++;
    if (!(Done === 1'b1 && Busy === 1'b0 && SadReady === 1'b0 && MinSad === em &&
          MinRow === 6'(ei / 3) && MinCol === 6'(ei % 3))) begin
      errors++;
      $display("FAIL %s_done: done=%b busy=%b ready=%b min=%h row=%0d col=%0d need 1 0 0 %h %0d %0d",
               name, Done, Busy, SadReady, MinSad, MinRow, MinCol, em, ei / 3, ei % 3);
    end
    step();
    checks++;
    if (!(Done === 1'b0 && Busy === 1'b0 && MinSad === em)) begin
      errors++;
      $display("FAIL %s_after: done=%b busy=%b min=%h need 0 0 %h", name, Done, Busy, MinSad, em);
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    Start = 1'b1;
    step();
    step();
    Start = 1'b0;
    checks++;
    if (!(MinSad === 32'd0 && MinRow === 6'd0 && MinCol === 6'd0 && Busy === 1'b0 &&
          Done === 1'b0 && SadReady === 1'b0)) begin
      errors++;
      $display("FAIL reset: min=%h row=%0d col=%0d busy=%b done=%b ready=%b need all 0",
               MinSad, MinRow, MinCol, Busy, Done, SadReady);
    end
    Rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_scan();
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      SadValid = 1'b1;
      SadIn = 32'd100 - 32'(i);
      step();
    end
    Rst_n = 1'b0;
    step();
    SadValid = 1'b0;
    checks++;
    if (!(MinSad === 32'd0 && MinRow === 6'd0 && MinCol === 6'd0 && Busy === 1'b0 &&
          Done === 1'b0 && SadReady === 1'b0)) begin
      errors++;
      $display("FAIL reset_mid_scan: min=%h row=%0d col=%0d busy=%b done=%b ready=%b need all 0",
               MinSad, MinRow, MinCol, Busy, Done, SadReady);
    end
    Rst_n = 1'b1;
    step();
  endtask

  task automatic test_descending();
    for (int i = 0; i < N; i++) cur[i] = 32'(9 - i);
    run_search("descending", 0);
  endtask

  task automatic test_ties();
    cur[0] = 5; cur[1] = 3; cur[2] = 3; cur[3] = 7;
    for (int i = 4; i < N; i++) cur[i] = 32'($urandom_range(3, 50));
    cur[5] = 3;
    run_search("ties", 0);
  endtask

  task automatic test_row_wrap();
    for (int i = 0; i < N; i++) cur[i] = 32'h100 + 32'($urandom_range(0, 255));
    cur[3] = 32'h10;
    run_search("row_wrap", 1);
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < N; i++) cur[i] = 32'hFFFF_FFFF;
    run_search("all_ones", 0);
  endtask

  task automatic test_abort();
    logic [31:0] em;
    int ei;
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cur[i] = 32'd50 + 32'($urandom_range(0, 20));
      SadValid = 1'b1;
      SadIn = cur[i];
      step();
    end
    Abort = 1'b1;
    SadIn = 32'd0;
    step();
    Abort = 1'b0;
    SadValid = 1'b0;
    model(4, em, ei);
    checks++;
    if (!(Busy === 1'b0 && Done === 1'b0 && SadReady === 1'b0 && MinSad === em &&
          MinRow === 6'(ei / 3) && MinCol === 6'(ei % 3))) begin
      errors++;
      $display("FAIL abort: busy=%b done=%b ready=%b min=%h row=%0d col=%0d need 0 0 0 %h %0d %0d",
               Busy, Done, SadReady, MinSad, MinRow, MinCol, em, ei / 3, ei % 3);
    end
    step();
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || MinSad !== em) begin
      errors++;
      $display("FAIL abort_hold: done=%b busy=%b min=%h need 0 0 %h", Done, Busy, MinSad, em);
    end
    for (int i = 0; i < N; i++) cur[i] = 32'($urandom_range(0, 1000));
    run_search("after_abort", 0);
  endtask

  task automatic test_start_held();
    Start = 1'b1;
    step();
    cur[0] = 4; cur[1] = 2; cur[2] = 9;
    for (int i = 3; i < N; i++) cur[i] = 7;
    for (int i = 0; i < N; i++) begin
      SadValid = 1'b1;
      SadIn = cur[i];
      step();
      if (i == 2) begin
        checks++;
        if (MinSad !== 32'd2 || MinCol !== 6'd1 || Busy !== 1'b1) begin
          errors++;
          $display("FAIL start_held_scan: min=%h col=%0d busy=%b need 2 1 1", MinSad, MinCol, Busy);
        end
      end
    end
    SadValid = 1'b0;
    checks++;
    if (Done !== 1'b1 || MinSad !== 32'd2 || MinRow !== 6'd0 || MinCol !== 6'd1) begin
      errors++;
      $display("FAIL start_held_done: done=%b min=%h row=%0d col=%0d need 1 2 0 1",
               Done, MinSad, MinRow, MinCol);
    end
    step();
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || MinSad !== 32'd2) begin
      errors++;
      $display("FAIL start_held_idle: busy=%b done=%b min=%h need 0 0 2", Busy, Done, MinSad);
    end
    step();
    checks++;
    if (Busy !== 1'b1 || MinSad !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL start_held_restart: busy=%b min=%h need 1 ffffffff", Busy, MinSad);
    end
    Start = 1'b0;
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    checks++;
    if (Busy !== 1'b0 || MinSad !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL start_held_abort: busy=%b min=%h need 0 ffffffff", Busy, MinSad);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++)
        cur[i] = (r % 2 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_search("random", 2);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N; i++) cur[i] = 32'($urandom_range(0, 7));
    run_search("b2b_a", 0);
    for (int i = 0; i < N; i++) cur[i] = 32'($urandom_range(0, 7));
    run_search("b2b_b", 0);
  endtask

  initial begin
    Rst_n = 1'b0;
    Start = 1'b0;
    Abort = 1'b0;
    SadIn = '0;
    SadValid = 1'b0;
    test_reset();
    test_descending();
    test_ties();
    test_row_wrap();
    test_all_ones();
    test_abort();
    test_start_held();
    test_reset_mid_scan();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
